// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse-width capture block.
package pulse_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_INACTIVE = 3'd1,
    ST_WAIT_EDGE     = 3'd2,
    ST_MEASURE       = 3'd3,
    ST_HOLD          = 3'd4
  } state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_capture_sync_edge.sv
// Pin synchronizer with active-level normalisation and rising-edge detect on the
// normalised signal.
module pulse_capture_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic polarity,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1] ~^ polarity;
  assign rise = s & ~s_d;

endmodule

// File: rtl/pulse_capture.sv
// Pulse-width capture: counts clock cycles that sig_in spends at its active level
// and holds the result until acknowledged.
//
// state          | meaning
// IDLE           | disarmed, count cleared
// WAIT_INACTIVE  | armed, waiting for s=0 so a pulse in progress is not measured
// WAIT_EDGE      | armed, waiting for the leading edge
// MEASURE        | counting active cycles (saturating)
// HOLD           | result valid, waiting for ack
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             polarity,
  input  logic             sig_in,
  input  logic             ack,
  output logic [WIDTH-1:0] capture,
  output logic             valid,
  output logic             overflow,
  output logic             missed,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count;
  logic             s, rise, sat;
  logic             cnt_clr, cnt_load, cnt_inc, cap_load, res_clear, miss_set;

  pulse_capture_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .polarity (polarity),
    .sig_in   (sig_in),
    .s        (s),
    .rise     (rise)
  );

  assign sat = (count == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:          if (enable) state_nxt = ST_WAIT_INACTIVE;
      ST_WAIT_INACTIVE: if (!enable) state_nxt = ST_IDLE;
                        else if (!s) state_nxt = ST_WAIT_EDGE;
      ST_WAIT_EDGE:     if (!enable) state_nxt = ST_IDLE;
                        else if (s) state_nxt = ST_MEASURE;
      ST_MEASURE:       if (!enable) state_nxt = ST_IDLE;
                        else if (!s) state_nxt = ST_HOLD;
      ST_HOLD:          if (ack) state_nxt = enable ? ST_WAIT_INACTIVE : ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_MEASURE);
    cnt_clr   = (state == ST_IDLE);
    cnt_load  = (state == ST_WAIT_EDGE) && enable && s;
    cnt_inc   = (state == ST_MEASURE) && enable && s;
    cap_load  = (state == ST_MEASURE) && enable && !s;
    res_clear = (state == ST_HOLD) && ack;
    // The acknowledging edge wins over a coincident leading edge.
    miss_set  = (state == ST_HOLD) && rise && !ack;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      capture  <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      missed   <= 1'b0;
    end else begin
      if (cnt_clr)                count <= '0;
      else if (cnt_load)          count <= WIDTH'(1);
      else if (cnt_inc && !sat)   count <= count + 1'b1;

      if (cap_load) begin
        capture  <= count;
        overflow <= sat;
        valid    <= 1'b1;
      end else if (res_clear) begin
        valid    <= 1'b0;
        overflow <= 1'b0;
        missed   <= 1'b0;
      end else if (miss_set) begin
        missed   <= 1'b1;
      end
    end
  end

endmodule
